// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// access-size field and base byte-enable patterns.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic funct3_valid(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// bus, and extraction plus sign/zero extension of the returned load lane.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_byte   = 8'(i_mem_rdata >> {i_addr_lo, 3'b000});
    assign w_half   = 16'(i_mem_rdata >> {i_addr_lo[1], 4'b0000});
    assign w_signed = ~i_funct3[2];

    // Halfword and word accesses ignore the low address bits they cannot use.
    always_comb begin
        o_be         = BE_WORD;
        o_wdata      = i_store_data;
        o_load_value = i_mem_rdata;
        case (i_funct3[1:0])
            SIZE_BYTE: begin
                o_be         = BE_BYTE << i_addr_lo;
                o_wdata      = {4{i_store_data[7:0]}};
                o_load_value = {{24{w_byte[7] & w_signed}}, w_byte};
            end
            SIZE_HALF: begin
                o_be         = BE_HALF << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_value = {{16{w_half[15] & w_signed}}, w_half};
            end
            default: begin
                o_be         = BE_WORD;
                o_wdata      = i_store_data;
                o_load_value = i_mem_rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> DONE with ack timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld_req,
    input  logic        i_st_req,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_read_address,
    input  logic [31:0] i_write_address,
    input  logic [31:0] i_store_data,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_load_data,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_error,
    output logic        o_busy
);

    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    lsu_state_e       r_state;
    lsu_state_e       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_err;
    logic             w_err_next;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [31:0]      r_load_data;

    logic             w_capture;
    logic             w_load_latch;
    logic             w_in_req;
    logic             w_in_done;
    logic [31:0]      w_in_addr;
    logic             w_in_valid;
    logic             w_misalign;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_value;

    assign w_in_addr  = i_st_req ? i_write_address : i_read_address;
    assign w_in_valid = funct3_valid(i_st_req, i_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((i_funct3[1:0] == SIZE_HALF) && w_in_addr[0]) ||
                        ((i_funct3[1:0] == SIZE_WORD) && (w_in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Rejected requests (dual, bad funct3, trapped misalignment) skip REQ entirely.
    always_comb begin
        w_next_state = r_state;
        w_count_next = r_count;
        w_err_next   = r_err;
        w_capture    = 1'b0;
        w_load_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_count_next = '0;
                if (i_ld_req && i_st_req) begin
                    w_next_state = S_DONE;
                    w_err_next   = 1'b1;
                end else if (i_ld_req || i_st_req) begin
                    w_capture = 1'b1;
                    if (!w_in_valid || w_misalign) begin
                        w_next_state = S_DONE;
                        w_err_next   = 1'b1;
                    end else begin
                        w_next_state = S_REQ;
                        w_err_next   = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_ack) begin
                    w_next_state = S_DONE;
                    w_err_next   = 1'b0;
                    w_load_latch = !r_is_store;
                end else if (r_count == CNT_LAST) begin
                    w_next_state = S_DONE;
                    w_err_next   = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_err_next   = 1'b0;
            end
            default: begin
                w_next_state = S_IDLE;
                w_err_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_data      <= '0;
            r_load_data <= '0;
        end else begin
            if (w_capture) begin
                r_is_store <= i_st_req;
                r_funct3   <= i_funct3;
                r_addr     <= w_in_addr;
                r_data     <= i_store_data;
            end
            if (w_load_latch)
                r_load_data <= w_load_value;
        end
    end

    lsu_lane_align u_lane_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_data),
        .i_mem_rdata  (i_mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_value (w_load_value)
    );

    // Bus outputs are gated by state so reset clears them without waiting for a clock.
    assign w_in_req    = (r_state == S_REQ);
    assign w_in_done   = (r_state == S_DONE);
    assign o_mem_req   = w_in_req;
    assign o_mem_we    = w_in_req & r_is_store;
    assign o_mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign o_mem_wdata = w_in_req ? w_wdata : 32'h0;
    assign o_mem_be    = w_in_req ? w_be : 4'h0;
    assign o_load_data = r_load_data;
    assign o_done      = w_in_done;
    assign o_error     = w_in_done & r_err;
    assign o_rd_valid  = w_in_done & ~r_err & ~r_is_store;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default WAIT_LIMIT of 16).
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ldReq;
    logic        stReq;
    logic [2:0]  funct3;
    logic [31:0] readAddress;
    logic [31:0] writeAddress;
    logic [31:0] storeData;
    logic        memAck;
    logic [31:0] memRdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic [31:0] loadData;
    logic        rdValid;
    logic        done;
    logic        error;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    int reqCycles;
    logic sawDone;

    load_store_unit #(.WAIT_LIMIT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_ld_req        (ldReq),
        .i_st_req        (stReq),
        .i_funct3        (funct3),
        .i_read_address  (readAddress),
        .i_write_address (writeAddress),
        .i_store_data    (storeData),
        .i_mem_ack       (memAck),
        .i_mem_rdata     (memRdata),
        .o_mem_req       (memReq),
        .o_mem_we        (memWe),
        .o_mem_addr      (memAddr),
        .o_mem_wdata     (memWdata),
        .o_mem_be        (memBe),
        .o_load_data     (loadData),
        .o_rd_valid      (rdValid),
        .o_done          (done),
        .o_error         (error),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Presents one request for a single capture edge, returning at the following negedge.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ldReq        = ld;
        stReq        = st;
        funct3       = f3;
        readAddress  = addr;
        writeAddress = addr;
        storeData    = data;
        @(negedge clk);
        ldReq = 1'b0;
        stReq = 1'b0;
    endtask

    // Acks the current REQ cycle, returning at the negedge inside DONE.
    task automatic ackWith(input logic [31:0] rdata);
        memAck   = 1'b1;
        memRdata = rdata;
        @(negedge clk);
        memAck   = 1'b0;
        memRdata = 32'h0;
    endtask

    initial begin
        rst          = 1'b1;
        ldReq        = 1'b0;
        stReq        = 1'b0;
        funct3       = 3'b000;
        readAddress  = 32'h0;
        writeAddress = 32'h0;
        storeData    = 32'h0;
        memAck       = 1'b0;
        memRdata     = 32'h0;

        @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_memreq", {31'h0, memReq}, 32'h0);
        checkOutput("reset_loaddata", loadData, 32'h0);
        rst = 1'b0;

        // LW 0x100, held one extra cycle with an ignored store request in flight
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        checkOutput("lw_memreq", {31'h0, memReq}, 32'h1);
        checkOutput("lw_addr", memAddr, 32'h0000_0100);
        checkOutput("lw_be", {28'h0, memBe}, 32'hF);
        checkOutput("lw_we", {31'h0, memWe}, 32'h0);
        checkOutput("lw_busy", {31'h0, busy}, 32'h1);
        stReq        = 1'b1;
        writeAddress = 32'h0000_0400;
        @(negedge clk);
        stReq = 1'b0;
        checkOutput("busy_ignore_addr", memAddr, 32'h0000_0100);
        checkOutput("busy_ignore_we", {31'h0, memWe}, 32'h0);
        ackWith(32'hDEAD_BEEF);
        checkOutput("lw_done", {31'h0, done}, 32'h1);
        checkOutput("lw_rdvalid", {31'h0, rdValid}, 32'h1);
        checkOutput("lw_error", {31'h0, error}, 32'h0);
        checkOutput("lw_data", loadData, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("lw_rdvalid_drop", {31'h0, rdValid}, 32'h0);
        checkOutput("lw_idle", {31'h0, busy}, 32'h0);

        // LB / LBU at 0x103
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        checkOutput("lb_be", {28'h0, memBe}, 32'h8);
        checkOutput("lb_addr", memAddr, 32'h0000_0100);
        ackWith(32'h80FF_1234);
        checkOutput("lb_data", loadData, 32'hFFFF_FF80);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        ackWith(32'h80FF_1234);
        checkOutput("lbu_data", loadData, 32'h0000_0080);
        checkOutput("lbu_rdvalid", {31'h0, rdValid}, 32'h1);

        // LH at 0x102 picks the upper halfword and sign-extends
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
        checkOutput("lh_be", {28'h0, memBe}, 32'hC);
        ackWith(32'h8001_0000);
        checkOutput("lh_data", loadData, 32'hFFFF_8001);

        // SH at 0x22; load_data must keep the last loaded value
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD);
        checkOutput("sh_addr", memAddr, 32'h0000_0020);
        checkOutput("sh_be", {28'h0, memBe}, 32'hC);
        checkOutput("sh_wdata", memWdata, 32'hABCD_ABCD);
        checkOutput("sh_we", {31'h0, memWe}, 32'h1);
        ackWith(32'h0);
        checkOutput("sh_done", {31'h0, done}, 32'h1);
        checkOutput("sh_rdvalid", {31'h0, rdValid}, 32'h0);
        checkOutput("sh_error", {31'h0, error}, 32'h0);
        checkOutput("sh_loaddata_hold", loadData, 32'hFFFF_8001);

        // SB at 0x41 replicates the low byte into every lane
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h1234_5678);
        checkOutput("sb_be", {28'h0, memBe}, 32'h2);
        checkOutput("sb_wdata", memWdata, 32'h7878_7878);
        ackWith(32'h0);

        // Ack never arrives: 16 REQ cycles then a timeout error
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        reqCycles = 0;
        sawDone   = 1'b0;
        for (int i = 0; i < 40 && !sawDone; i++) begin
            if (done) begin
                sawDone = 1'b1;
            end else begin
                if (memReq) reqCycles++;
                @(negedge clk);
            end
        end
        checkOutput("timeout_reached_done", {31'h0, sawDone}, 32'h1);
        checkOutput("timeout_req_cycles", reqCycles, 32'd16);
        checkOutput("timeout_error", {31'h0, error}, 32'h1);
        checkOutput("timeout_rdvalid", {31'h0, rdValid}, 32'h0);
        checkOutput("timeout_memreq", {31'h0, memReq}, 32'h0);
        @(negedge clk);

        // Misaligned LW at 0x102
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("misalign_memreq", {31'h0, memReq}, 32'h0);
        checkOutput("misalign_error", {31'h0, error}, 32'h1);
        checkOutput("misalign_done", {31'h0, done}, 32'h1);
        @(negedge clk);
`else
        checkOutput("misalign_addr", memAddr, 32'h0000_0100);
        checkOutput("misalign_be", {28'h0, memBe}, 32'hF);
        ackWith(32'h1234_5678);
        checkOutput("misalign_data", loadData, 32'h1234_5678);
        checkOutput("misalign_error", {31'h0, error}, 32'h0);
        @(negedge clk);
`endif

        // Invalid funct3 for a load
        applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        checkOutput("badf3_memreq", {31'h0, memReq}, 32'h0);
        checkOutput("badf3_error", {31'h0, error}, 32'h1);
        @(negedge clk);

        // Dual request
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0);
        checkOutput("dual_memreq", {31'h0, memReq}, 32'h0);
        checkOutput("dual_done", {31'h0, done}, 32'h1);
        checkOutput("dual_error", {31'h0, error}, 32'h1);
        @(negedge clk);
        checkOutput("dual_idle", {31'h0, busy}, 32'h0);

        // Reset asserted mid-REQ, away from any clock edge
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        checkOutput("rstmid_memreq_before", {31'h0, memReq}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_memreq", {31'h0, memReq}, 32'h0);
        checkOutput("rstmid_busy", {31'h0, busy}, 32'h0);
        checkOutput("rstmid_addr", memAddr, 32'h0);
        checkOutput("rstmid_be", {28'h0, memBe}, 32'h0);
        checkOutput("rstmid_loaddata", loadData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle", {31'h0, busy}, 32'h0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: maximum cycles in REQ state waiting for mem_ack before timeout.
REQ-002 SHALL have port clk  in  1  clock, rising edge; reset rst, asynchronous, active-high.
REQ-003 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port ld_req  in  1  load request, sampled in IDLE.
REQ-005 SHALL have port st_req  in  1  store request, sampled in IDLE.
REQ-006 SHALL have port funct3  in  3  access size/sign code.
REQ-007 SHALL have ports read_address / write_address  in  32  byte address from ALU for load / store.
REQ-008 SHALL have port store_data  in  32  store data from ALU.
REQ-009 SHALL have ports mem_ack  in  1 and mem_rdata  in  32  memory response.
REQ-010 SHALL have ports mem_req, mem_we  out  1;  mem_addr, mem_wdata  out  32;  mem_be  out  4.
REQ-011 SHALL have ports load_data  out  32;  rd_valid, done, error, busy  out  1.

Function
REQ-012 SHALL implement FSM IDLE -> REQ -> DONE -> IDLE; busy = (state != IDLE).
REQ-013 In IDLE, a single asserted ld_req or st_req SHALL be captured (address, funct3, data, direction) and move to REQ next edge.
REQ-014 ld_req and st_req both high in IDLE SHALL go directly to DONE with error=1 and no bus cycle.
REQ-015 Requests while busy SHALL be ignored.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata stable until the cycle mem_ack=1 is sampled.
REQ-017 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-018 Valid funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code SHALL go to DONE with error=1, no bus cycle.
REQ-019 Store lanes: SB wdata={4{d[7:0]}}, be=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, be=0011<<{addr[1],0}; SW wdata=d, be=1111.
REQ-020 Loads SHALL set mem_be per REQ-019 rule, mem_we=0; read lane = mem_rdata>>(8*addr[1:0]) (halfword: 16*addr[1]), sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-021 On mem_ack in REQ: load_data SHALL register the extended value; state -> DONE.
REQ-022 DONE SHALL last exactly one cycle: done=1; rd_valid=1 only for successful loads; error=1 for failed ops; then IDLE.
REQ-023 Minimum latency: request at edge N, mem_req high after N, ack sampled at N+1, done high after N+1 to N+2.
REQ-024 A counter SHALL count REQ cycles; on reaching WAIT_LIMIT without ack, mem_req drops, state -> DONE with error=1, rd_valid=0.
REQ-025 load_data SHALL hold its value until the next successful load.

Reset
REQ-026 rst SHALL immediately force state IDLE, clear counter, and drive all outputs 0, including mid-transaction (mem_req drops asynchronously).

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go to DONE with error=1, no bus cycle.
REQ-028 Macro undefined: misaligned low bits SHALL be ignored (word uses addr[1:0]=0, halfword uses addr[0]=0) and the access proceeds normally.

Structure
REQ-029 Package lsu_pkg SHALL hold the state enum, funct3 load/store constants and the byte-enable encoding.
REQ-030 Combinational sub-module lsu_lane_align SHALL compute mem_be, mem_wdata and extended load value.

Verification
REQ-031 LW at 0x100, mem_rdata=0xDEADBEEF, ack after 1 cycle -> mem_addr=0x100, be=1111, load_data=0xDEADBEEF, rd_valid one cycle.
REQ-032 LB at 0x103, rdata=0x80FF_1234 -> be=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH at 0x22, store_data=0x0000ABCD -> mem_addr=0x20, be=1100, wdata=0xABCDABCD, mem_we=1, done=1, rd_valid=0.
REQ-034 LW with mem_ack never asserted, WAIT_LIMIT=16 -> mem_req high 16 cycles, then done=1, error=1.
REQ-035 LW at 0x102 -> with LSU_MISALIGN_TRAP_EN: no mem_req, error=1; without: mem_addr=0x100, normal completion.
REQ-036 rst pulsed while in REQ; separately ld_req and st_req both high -> mem_req drops at once, all outputs 0; dual request gives error=1, no bus cycle.
